// File: rtl/risc_pkg.sv
// Shared types and constants for the 8-bit RISC core pipeline.
package risc_pkg;

  localparam int DATA_W  = 8;
  localparam int REG_AW  = 2;
  localparam int ALU_OPW = 4;
  // Operand ports per instruction: index 0 = ra, index 1 = rb.
  localparam int NUM_OPS = 2;

  localparam logic [REG_AW-1:0] SP_ADDR = 2'd3;

  typedef enum logic [ALU_OPW-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_SHR = 4'd6,
    ALU_MOV = 4'd7,
    ALU_CMP = 4'd8
  } alu_op_e;

  // Everything the ID/EX register holds for one instruction.
  typedef struct packed {
    logic                             valid;
    logic                             we;
    logic                             mem_rd;
    logic [ALU_OPW-1:0]               alu_op;
    logic [REG_AW-1:0]                wr_addr;
    logic [DATA_W-1:0]                imm;
    logic [NUM_OPS-1:0][REG_AW-1:0]   src_addr;
    logic [NUM_OPS-1:0][DATA_W-1:0]   src_data;
  } ex_ctrl_t;

  // A bubble kills valid/we/mem_rd; the rest is zeroed so it stays quiet.
  localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode / downstream-writeback / execute bundle around the ID/EX register.
interface id_ex_stage_if;
  import risc_pkg::*;

  logic               id_valid;
  logic [REG_AW-1:0]  id_ra_addr, id_rb_addr;
  logic               id_ra_used, id_rb_used;
  logic [DATA_W-1:0]  id_ra_data, id_rb_data;
  logic [REG_AW-1:0]  id_wr_addr;
  logic               id_we;
  logic               id_mem_rd;
  logic [ALU_OPW-1:0] id_alu_op;
  logic [DATA_W-1:0]  id_imm;
  logic               flush;

  logic               exm_we;
  logic [REG_AW-1:0]  exm_wr_addr;
  logic [DATA_W-1:0]  exm_result;
  logic               mwb_we;
  logic [REG_AW-1:0]  mwb_wr_addr;
  logic [DATA_W-1:0]  mwb_result;

  logic               stall;
  logic               ex_valid;
  logic [DATA_W-1:0]  ex_a, ex_b;
  logic [REG_AW-1:0]  ex_ra_addr, ex_rb_addr, ex_wr_addr;
  logic               ex_we, ex_mem_rd;
  logic [ALU_OPW-1:0] ex_alu_op;
  logic [DATA_W-1:0]  ex_imm;

  modport master (
    output id_valid, id_ra_addr, id_rb_addr, id_ra_used, id_rb_used,
           id_ra_data, id_rb_data, id_wr_addr, id_we, id_mem_rd,
           id_alu_op, id_imm, flush,
           exm_we, exm_wr_addr, exm_result, mwb_we, mwb_wr_addr, mwb_result,
    input  stall, ex_valid, ex_a, ex_b, ex_ra_addr, ex_rb_addr, ex_wr_addr,
           ex_we, ex_mem_rd, ex_alu_op, ex_imm
  );

  modport slave (
    input  id_valid, id_ra_addr, id_rb_addr, id_ra_used, id_rb_used,
           id_ra_data, id_rb_data, id_wr_addr, id_we, id_mem_rd,
           id_alu_op, id_imm, flush,
           exm_we, exm_wr_addr, exm_result, mwb_we, mwb_wr_addr, mwb_result,
    output stall, ex_valid, ex_a, ex_b, ex_ra_addr, ex_rb_addr, ex_wr_addr,
           ex_we, ex_mem_rd, ex_alu_op, ex_imm
  );

endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// Two-source priority bypass: hi write wins over lo write, else default.
module fwd_sel #(
  parameter int DATA_W = 8,
  parameter int AW     = 2
) (
  input  logic [AW-1:0]     src_addr,
  input  logic              hi_we,
  input  logic [AW-1:0]     hi_addr,
  input  logic [DATA_W-1:0] hi_data,
  input  logic              lo_we,
  input  logic [AW-1:0]     lo_addr,
  input  logic [DATA_W-1:0] lo_data,
  input  logic [DATA_W-1:0] dflt,
  output logic [DATA_W-1:0] y
);

  // Exact address match only; no arithmetic on the data path.
  always_comb begin
    y = dflt;
    if (hi_we && (hi_addr == src_addr))      y = hi_data;
    else if (lo_we && (lo_addr == src_addr)) y = lo_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with capture bypass, EX forwarding and load-use stall.
module id_ex_stage
  import risc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  id_ex_stage_if.slave  bus
);

  ex_ctrl_t ctrl_d, ctrl_q;

  logic [NUM_OPS-1:0][REG_AW-1:0] id_src_addr;
  logic [NUM_OPS-1:0]             id_src_used;
  logic [NUM_OPS-1:0][DATA_W-1:0] id_src_data;
  logic [NUM_OPS-1:0][DATA_W-1:0] cap_data;
  logic [NUM_OPS-1:0][DATA_W-1:0] ex_fwd;
  logic                           load_use;
  logic                           stall_w;

  assign id_src_addr = {bus.id_rb_addr, bus.id_ra_addr};
  assign id_src_used = {bus.id_rb_used, bus.id_ra_used};
  assign id_src_data = {bus.id_rb_data, bus.id_ra_data};

  // Per operand: capture bypass covers a register-file write landing in the
  // same cycle as the read; execute bypass takes EX/MEM over MEM/WB.
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_sel #(.DATA_W(DATA_W), .AW(REG_AW)) u_cap (
      .src_addr (id_src_addr[g]),
      .hi_we    (1'b0),
      .hi_addr  ({REG_AW{1'b0}}),
      .hi_data  ({DATA_W{1'b0}}),
      .lo_we    (bus.mwb_we),
      .lo_addr  (bus.mwb_wr_addr),
      .lo_data  (bus.mwb_result),
      .dflt     (id_src_data[g]),
      .y        (cap_data[g])
    );

    fwd_sel #(.DATA_W(DATA_W), .AW(REG_AW)) u_ex (
      .src_addr (ctrl_q.src_addr[g]),
      .hi_we    (bus.exm_we),
      .hi_addr  (bus.exm_wr_addr),
      .hi_data  (bus.exm_result),
      .lo_we    (bus.mwb_we),
      .lo_addr  (bus.mwb_wr_addr),
      .lo_data  (bus.mwb_result),
      .dflt     (ctrl_q.src_data[g]),
      .y        (ex_fwd[g])
    );
  end

  // Load in EX whose destination is read by the instruction in decode.
  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_OPS; i++)
      if (id_src_used[i] && (id_src_addr[i] == ctrl_q.wr_addr)) load_use = 1'b1;
    load_use = load_use & ctrl_q.valid & ctrl_q.mem_rd & ctrl_q.we & bus.id_valid;
  end

  // Flush dominates: the killed instruction cannot cause a stall.
  assign stall_w = load_use & ~bus.flush;

  // Next register contents: bubble on flush/stall/empty decode, else capture.
  always_comb begin
    ctrl_d = EX_BUBBLE;
    if (!bus.flush && !stall_w && bus.id_valid) begin
      ctrl_d.valid    = 1'b1;
      ctrl_d.we       = bus.id_we;
      ctrl_d.mem_rd   = bus.id_mem_rd;
      ctrl_d.alu_op   = bus.id_alu_op;
      ctrl_d.wr_addr  = bus.id_wr_addr;
      ctrl_d.imm      = bus.id_imm;
      ctrl_d.src_addr = id_src_addr;
      ctrl_d.src_data = cap_data;
    end
  end

  // ID/EX register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ctrl_q <= EX_BUBBLE;
    else      ctrl_q <= ctrl_d;
  end

  assign bus.stall      = stall_w;
  assign bus.ex_valid   = ctrl_q.valid;
  assign bus.ex_we      = ctrl_q.we;
  assign bus.ex_mem_rd  = ctrl_q.mem_rd;
  assign bus.ex_alu_op  = ctrl_q.alu_op;
  assign bus.ex_wr_addr = ctrl_q.wr_addr;
  assign bus.ex_imm     = ctrl_q.imm;
  assign bus.ex_ra_addr = ctrl_q.src_addr[0];
  assign bus.ex_rb_addr = ctrl_q.src_addr[1];
  assign bus.ex_a       = ex_fwd[0];
  assign bus.ex_b       = ex_fwd[1];

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random model run.
module tb_id_ex_stage;
  import risc_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.id_valid = 1'b0;  bus.id_ra_addr = '0; bus.id_rb_addr = '0;
    bus.id_ra_used = 1'b0; bus.id_rb_used = 1'b0;
    bus.id_ra_data = '0;  bus.id_rb_data = '0; bus.id_wr_addr = '0;
    bus.id_we = 1'b0;     bus.id_mem_rd = 1'b0; bus.id_alu_op = '0;
    bus.id_imm = '0;      bus.flush = 1'b0;
    bus.exm_we = 1'b0;    bus.exm_wr_addr = '0; bus.exm_result = '0;
    bus.mwb_we = 1'b0;    bus.mwb_wr_addr = '0; bus.mwb_result = '0;
  endtask

  // Present an instruction in decode (all downstream writes off).
  task automatic present(input logic [1:0] ra, input logic [1:0] rb,
                         input logic [7:0] da, input logic [7:0] db,
                         input logic [1:0] wr, input logic we, input logic ld,
                         input logic [3:0] op, input logic [7:0] imm);
    idle();
    bus.id_valid = 1'b1;
    bus.id_ra_addr = ra; bus.id_rb_addr = rb;
    bus.id_ra_used = 1'b1; bus.id_rb_used = 1'b1;
    bus.id_ra_data = da; bus.id_rb_data = db;
    bus.id_wr_addr = wr; bus.id_we = we; bus.id_mem_rd = ld;
    bus.id_alu_op = op; bus.id_imm = imm;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.ex_valid); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", bus.stall); end
    total++; if (bus.ex_a !== 8'h00 || bus.ex_b !== 8'h00) begin
      bad++; $display("FAIL reset_ops got=%0h/%0h exp=0/0", bus.ex_a, bus.ex_b); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plain_capture();
    present(2'd1, 2'd2, 8'h12, 8'h34, 2'd3, 1'b1, 1'b0, 4'd1, 8'h5A);
    @(negedge clk);
    idle();
    #1;
    total++; if (bus.ex_valid !== 1'b1) begin bad++; $display("FAIL cap_valid got=%0h exp=1", bus.ex_valid); end
    total++; if (bus.ex_a !== 8'h12 || bus.ex_b !== 8'h34) begin
      bad++; $display("FAIL cap_ops got=%0h/%0h exp=12/34", bus.ex_a, bus.ex_b); end
    total++; if (bus.ex_alu_op !== 4'd1 || bus.ex_imm !== 8'h5A || bus.ex_wr_addr !== 2'd3) begin
      bad++; $display("FAIL cap_ctl got=%0h/%0h/%0h exp=1/5a/3", bus.ex_alu_op, bus.ex_imm, bus.ex_wr_addr); end
  endtask

  task automatic test_same_cycle_wb();
    present(2'd1, 2'd2, 8'h12, 8'h34, 2'd0, 1'b0, 1'b0, 4'd2, 8'h00);
    bus.mwb_we = 1'b1; bus.mwb_wr_addr = 2'd1; bus.mwb_result = 8'h55;
    @(negedge clk);
    idle();
    #1;
    total++; if (bus.ex_a !== 8'h55) begin bad++; $display("FAIL wb_bypass_a got=%0h exp=55", bus.ex_a); end
    total++; if (bus.ex_b !== 8'h34) begin bad++; $display("FAIL wb_bypass_b got=%0h exp=34", bus.ex_b); end
  endtask

  task automatic test_fwd_priority();
    present(2'd1, 2'd2, 8'h12, 8'h34, 2'd0, 1'b0, 1'b0, 4'd3, 8'h00);
    @(negedge clk);
    idle();
    bus.exm_we = 1'b1; bus.exm_wr_addr = 2'd2; bus.exm_result = 8'hAA;
    bus.mwb_we = 1'b1; bus.mwb_wr_addr = 2'd2; bus.mwb_result = 8'hBB;
    #1;
    total++; if (bus.ex_b !== 8'hAA) begin bad++; $display("FAIL fwd_exm_prio got=%0h exp=aa", bus.ex_b); end
    bus.exm_we = 1'b0;
    #1;
    total++; if (bus.ex_b !== 8'hBB) begin bad++; $display("FAIL fwd_mwb got=%0h exp=bb", bus.ex_b); end
    total++; if (bus.ex_a !== 8'h12) begin bad++; $display("FAIL fwd_no_hit got=%0h exp=12", bus.ex_a); end
  endtask

  task automatic test_load_use();
    present(2'd2, 2'd3, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1, 4'd7, 8'h00);
    bus.id_ra_used = 1'b0; bus.id_rb_used = 1'b0;
    @(negedge clk);
    present(2'd0, 2'd1, 8'h11, 8'h22, 2'd2, 1'b1, 1'b0, 4'd0, 8'h00);
    bus.id_rb_used = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%0h exp=1", bus.stall); end
    @(negedge clk);
    bus.exm_we = 1'b1; bus.exm_wr_addr = 2'd0; bus.exm_result = 8'h7E;
    #1;
    total++; if (bus.ex_valid !== 1'b0 || bus.stall !== 1'b0) begin
      bad++; $display("FAIL lu_bubble got=%0h/%0h exp=0/0", bus.ex_valid, bus.stall); end
    @(negedge clk);
    idle();
    bus.exm_we = 1'b1; bus.exm_wr_addr = 2'd0; bus.exm_result = 8'h7E;
    bus.mwb_we = 1'b1; bus.mwb_wr_addr = 2'd0; bus.mwb_result = 8'h33;
    #1;
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_a !== 8'h7E) begin
      bad++; $display("FAIL lu_fwd got=%0h/%0h exp=1/7e", bus.ex_valid, bus.ex_a); end
  endtask

  task automatic test_flush_load_use();
    present(2'd2, 2'd3, 8'h00, 8'h00, 2'd1, 1'b1, 1'b1, 4'd7, 8'h00);
    @(negedge clk);
    present(2'd1, 2'd0, 8'h11, 8'h22, 2'd2, 1'b1, 1'b0, 4'd0, 8'h00);
    bus.flush = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%0h exp=0", bus.stall); end
    @(negedge clk);
    idle();
    #1;
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_we !== 1'b0) begin
      bad++; $display("FAIL flush_bubble got=%0h/%0h exp=0/0", bus.ex_valid, bus.ex_we); end
  endtask

  task automatic test_async_reset();
    present(2'd1, 2'd2, 8'h44, 8'h66, 2'd1, 1'b1, 1'b0, 4'd4, 8'h99);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.ex_valid !== 1'b0 || bus.ex_a !== 8'h00) begin
      bad++; $display("FAIL async_reset got=%0h/%0h exp=0/0", bus.ex_valid, bus.ex_a); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++; if (bus.ex_valid !== 1'b1 || bus.ex_b !== 8'h66) begin
      bad++; $display("FAIL reset_release got=%0h/%0h exp=1/66", bus.ex_valid, bus.ex_b); end
  endtask

  // Random run against an instruction-level model of the ID/EX register.
  task automatic test_random();
    logic       m_v, m_we, m_ld;
    logic [3:0] m_op;
    logic [1:0] m_wr, m_ra, m_rb;
    logic [7:0] m_imm, m_a, m_b;
    logic       e_stall;
    logic [7:0] e_a, e_b;
    logic [25:0] obs, exp;
    idle();
    @(negedge clk);
    @(negedge clk);
    {m_v, m_we, m_ld, m_op, m_wr, m_ra, m_rb, m_imm, m_a, m_b} = '0;
    for (int n = 0; n < 400; n++) begin
      bus.id_valid   = ($urandom_range(0, 3) != 0);
      bus.id_ra_addr = 2'($urandom);   bus.id_rb_addr = 2'($urandom);
      bus.id_ra_used = 1'($urandom);   bus.id_rb_used = 1'($urandom);
      bus.id_ra_data = 8'($urandom);   bus.id_rb_data = 8'($urandom);
      bus.id_wr_addr = 2'($urandom);   bus.id_we      = 1'($urandom);
      bus.id_mem_rd  = ($urandom_range(0, 2) == 0);
      bus.id_alu_op  = 4'($urandom);   bus.id_imm     = 8'($urandom);
      bus.flush      = ($urandom_range(0, 7) == 0);
      bus.exm_we     = 1'($urandom);   bus.exm_wr_addr = 2'($urandom);
      bus.exm_result = 8'($urandom);
      bus.mwb_we     = 1'($urandom);   bus.mwb_wr_addr = 2'($urandom);
      bus.mwb_result = 8'($urandom);
      #1;
      // Expected outputs from the instruction the model says is in EX.
      e_stall = m_v && m_ld && m_we && bus.id_valid && !bus.flush &&
                ((bus.id_ra_used && bus.id_ra_addr == m_wr) ||
                 (bus.id_rb_used && bus.id_rb_addr == m_wr));
      if (bus.exm_we && bus.exm_wr_addr == m_ra)      e_a = bus.exm_result;
      else if (bus.mwb_we && bus.mwb_wr_addr == m_ra) e_a = bus.mwb_result;
      else                                            e_a = m_a;
      if (bus.exm_we && bus.exm_wr_addr == m_rb)      e_b = bus.exm_result;
      else if (bus.mwb_we && bus.mwb_wr_addr == m_rb) e_b = bus.mwb_result;
      else                                            e_b = m_b;
      obs = {bus.ex_valid, bus.ex_we, bus.ex_mem_rd, bus.ex_alu_op, bus.ex_wr_addr,
             bus.ex_ra_addr, bus.ex_rb_addr, bus.ex_imm, bus.stall};
      exp = {m_v, m_we, m_ld, m_op, m_wr, m_ra, m_rb, m_imm, e_stall};
      total++; if (obs !== exp) begin
        bad++; $display("FAIL rnd_ctl[%0d] got=%0h exp=%0h", n, obs, exp); end
      total++; if (bus.ex_a !== e_a || bus.ex_b !== e_b) begin
        bad++; $display("FAIL rnd_ops[%0d] got=%0h/%0h exp=%0h/%0h", n, bus.ex_a, bus.ex_b, e_a, e_b); end
      // What EX holds after this edge.
      if (bus.flush || e_stall || !bus.id_valid) begin
        {m_v, m_we, m_ld, m_op, m_wr, m_ra, m_rb, m_imm, m_a, m_b} = '0;
      end else begin
        m_v = 1'b1; m_we = bus.id_we; m_ld = bus.id_mem_rd; m_op = bus.id_alu_op;
        m_wr = bus.id_wr_addr; m_ra = bus.id_ra_addr; m_rb = bus.id_rb_addr;
        m_imm = bus.id_imm;
        m_a = (bus.mwb_we && bus.mwb_wr_addr == m_ra) ? bus.mwb_result : bus.id_ra_data;
        m_b = (bus.mwb_we && bus.mwb_wr_addr == m_rb) ? bus.mwb_result : bus.id_rb_data;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    idle();
    test_reset();
    test_plain_capture();
    test_same_cycle_wb();
    test_fwd_priority();
    test_load_use();
    test_flush_load_use();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
